mul_div_unit: RTL

- Iterative multiply/divide unit for the multi-cycle MIPS datapath. Sits directly downstream of the register file.
- Consumes the two register read ports (rs → opa, rt → opb) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Holds the architectural HI/LO registers, which the write-back mux reads for MFHI/MFLO.
- The control FSM stalls on busy until done.

---
 rtl/mul_div_unit_pkg.sv | 26 ++
 rtl/mdu_sign_fix.sv | 13 +
 rtl/mul_div_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared op and state encodings for the iterative multiply/divide unit.
// The main control FSM decodes the same op values.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op inside {MDU_DIV, MDU_DIVU});
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op inside {MDU_MULT, MDU_DIV});
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: takes operand magnitudes on entry
// and restores the result sign on exit.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One multiply or divide iteration per cycle on unsigned magnitudes.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO writes accepted here
// RUN     | WIDTH iterations, counter 0..WIDTH-1
// DONE    | HI/LO hold the new result, done pulses for one cycle
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    mdu_op_e          op_in;
    logic             sa_in, sb_in;
    logic [WIDTH-1:0] opa_mag, opb_mag;

    assign op_in = mdu_op_e'(op);
    assign sa_in = op_is_signed(op_in) & opa[WIDTH-1];
    assign sb_in = op_is_signed(op_in) & opb[WIDTH-1];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.val(opa), .neg(sa_in), .res(opa_mag));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.val(opb), .neg(sb_in), .res(opb_mag));

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt;

    // Multiply: acc low half starts as the multiplier and is consumed LSB-first.
    // Divide: acc low half starts as the dividend and fills with quotient bits.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, ma_q};
        mul_nxt   = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mb_q};
        div_ge    = ~div_diff[WIDTH];
        rem_nxt   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_nxt   = {acc_q[WIDTH-2:0], div_ge};
    end

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.val(mul_nxt), .neg(sa_q ^ sb_q), .res(prod_fixed));
    mdu_sign_fix #(.WIDTH(WIDTH))   u_fix_quo  (.val(quo_nxt), .neg(sa_q ^ sb_q), .res(quo_fixed));
    mdu_sign_fix #(.WIDTH(WIDTH))   u_fix_rem  (.val(rem_nxt), .neg(sa_q),        .res(rem_fixed));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op_in;
                    sa_d  = sa_in;
                    sb_d  = sb_in;
                    ma_d  = opa_mag;
                    mb_d  = opb_mag;
                    cnt_d = '0;
                    rem_d = '0;
                    acc_d = {{WIDTH{1'b0}}, op_is_div(op_in) ? opa_mag : opb_mag};
                    if (op_is_div(op_in) && (opb == '0)) begin
                        hi_d    = opa;
                        lo_d    = '1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (op_is_div(op_q)) begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_nxt};
                    rem_d = rem_nxt;
                end else begin
                    acc_d = mul_nxt;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    if (op_is_div(op_q)) begin
                        hi_d = rem_fixed;
                        lo_d = quo_fixed;
                    end else begin
                        hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                        lo_d = prod_fixed[WIDTH-1:0];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= MDU_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
